// File: rtl/shared_reg_pkg.sv
// Shared types and defaults for the shared-register arbiter slice.
package shared_reg_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int N_REQ_DEF    = 4;
    localparam int DATA_W_DEF   = 8;
    localparam int MAX_HOLD_DEF = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin search: first set req bit at or after start, wrapping.
module rr_pick
    import shared_reg_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int PW    = (clog2(N_REQ) < 1) ? 1 : clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    start,
    output logic             found,
    output logic [PW-1:0]    idx
);

    always_comb begin
        int unsigned k;
        logic [PW-1:0] k_idx;
        found = 1'b0;
        idx   = '0;
        k     = 0;
        k_idx = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            k     = (int'(start) + off) % N_REQ;
            k_idx = PW'(k);
            if (!found && req[k_idx]) begin
                found = 1'b1;
                idx   = k_idx;
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one DATA_W-bit register among N_REQ requesters,
// with tenure bounded by MAX_HOLD cycles and back-to-back handoff.
module shared_reg_arbiter
    import shared_reg_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    localparam int OW      = (clog2(N_REQ) < 1) ? 1 : clog2(N_REQ),
    localparam int HW      = (clog2(MAX_HOLD) < 1) ? 1 : clog2(MAX_HOLD)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          we,
    input  logic [N_REQ*DATA_W-1:0]   wdata,
    output logic [N_REQ-1:0]          grant,
    output logic [OW-1:0]             owner,
    output logic                      busy,
    output logic [DATA_W-1:0]         q
);

    state_t            state;
    logic [OW-1:0]     rr_ptr;
    logic [HW-1:0]     hold_cnt;
    logic [OW-1:0]     nxt_ptr;
    logic [OW-1:0]     pick_start;
    logic [OW-1:0]     pick_idx;
    logic              pick_found;
    logic              owner_req;
    logic              owner_we;
    logic              release_now;
    logic [DATA_W-1:0] owner_wdata;

    // On release the owner's req bit is either already low or must be
    // searched last; starting at owner+1 covers both without extra masking.
    always_comb begin
        owner_req   = req[owner];
        owner_we    = we[owner];
        nxt_ptr     = (owner == OW'(N_REQ - 1)) ? '0 : owner + 1'b1;
        release_now = !owner_req || (hold_cnt == HW'(MAX_HOLD - 1));
        pick_start  = (state == GRANT) ? nxt_ptr : rr_ptr;
        owner_wdata = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (owner == OW'(i)) owner_wdata = wdata[i*DATA_W +: DATA_W];
        end
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (OW)
    ) u_pick (
        .req   (req),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            grant    <= '0;
            owner    <= '0;
            q        <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant    <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        owner    <= pick_idx;
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (owner_req && owner_we) q <= owner_wdata;
                    if (!release_now) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end else begin
                        rr_ptr <= nxt_ptr;
                        if (pick_found) begin
                            grant    <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                            owner    <= pick_idx;
                            hold_cnt <= '0;
                        end else begin
                            grant    <= '0;
                            owner    <= '0;
                            hold_cnt <= '0;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == GRANT);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed self-checking bench for shared_reg_arbiter (N_REQ=4, DATA_W=8, MAX_HOLD=4).
module tb_shared_reg_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic        busy;
    logic [7:0]  q;

    int n_checks;
    int n_fail;

    shared_reg_arbiter #(
        .N_REQ    (4),
        .DATA_W   (8),
        .MAX_HOLD (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .we    (we),
        .wdata (wdata),
        .grant (grant),
        .owner (owner),
        .busy  (busy),
        .q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    logic [3:0] rr_seq [4];
    logic [7:0] expq;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rr_seq[0] = 4'b0001;
        rr_seq[1] = 4'b0010;
        rr_seq[2] = 4'b1000;
        rr_seq[3] = 4'b0001;

        reset = 1'b0;
        req   = '0;
        we    = '0;
        wdata = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_grant", grant, 4'b0000);
        check_eq("rst_owner", owner, 0);
        check_eq("rst_busy",  busy,  0);
        check_eq("rst_q",     q,     0);
        reset = 1'b1;

        // Mid-tenure asynchronous reset while owner 1 holds the register
        req = 4'b0010; we = 4'b0010; wdata[8 +: 8] = 8'h3C;
        @(negedge clk);
        check_eq("mid_grant", grant, 4'b0010);
        @(negedge clk);
        check_eq("mid_q", q, 8'h3C);
        #2 reset = 1'b0;
        #1;
        check_eq("async_grant", grant, 4'b0000);
        check_eq("async_q",     q,     0);
        check_eq("async_owner", owner, 0);
        check_eq("async_busy",  busy,  0);
        @(negedge clk);
        reset = 1'b1; req = 4'b0001; we = '0;
        @(negedge clk);
        check_eq("post_rst_grant", grant, 4'b0001);
        req = '0;
        @(negedge clk);
        check_eq("post_rst_idle", busy, 0);

        // Single requester write and release
        req = 4'b0100; we = 4'b0100; wdata = '0; wdata[16 +: 8] = 8'hA5;
        @(negedge clk);
        check_eq("single_grant", grant, 4'b0100);
        check_eq("single_owner", owner, 2);
        check_eq("single_q0",    q,     0);
        @(negedge clk);
        check_eq("single_q1",    q,     8'hA5);
        req = '0; we = '0;
        @(negedge clk);
        check_eq("single_rel_busy",  busy,  0);
        check_eq("single_rel_grant", grant, 4'b0000);
        check_eq("single_rel_q",     q,     8'hA5);

        // Simultaneous requests from rr_ptr=0
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1; req = 4'b1011; we = '0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check_eq($sformatf("rr_grant%0d", k), grant, rr_seq[k/4]);
            check_eq($sformatf("rr_busy%0d", k),  busy,  1);
        end

        // Non-owner writes ignored
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1; req = 4'b0001; we = 4'b1111;
        wdata = '0; wdata[0 +: 8] = 8'h11; wdata[24 +: 8] = 8'hFF;
        @(negedge clk);
        check_eq("nonown_owner", owner, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq($sformatf("nonown_q%0d", k), q, 8'h11);
        end
        req = '0; we = '0;
        @(negedge clk);
        check_eq("nonown_idle", busy, 0);

        // Sole requester times out and is re-granted without a gap
        expq = 8'h11;
        req = 4'b0010;
        for (int k = 0; k < 10; k++) begin
            we = (k == 5) ? 4'b0000 : 4'b0010;
            wdata[8 +: 8] = 8'(8'h40 + k);
            @(negedge clk);
            if (k >= 1 && k != 5) expq = 8'(8'h40 + k);
            check_eq($sformatf("to_grant%0d", k), grant, 4'b0010);
            check_eq($sformatf("to_busy%0d", k),  busy,  1);
            check_eq($sformatf("to_q%0d", k),     q,     expq);
        end

        // Owner 0 drops req while req[2] pending: direct handoff
        #2 reset = 1'b0; req = '0; we = '0;
        @(negedge clk);
        reset = 1'b1; req = 4'b0001;
        @(negedge clk);
        check_eq("ho_grant0", grant, 4'b0001);
        req = 4'b0100;
        @(negedge clk);
        check_eq("ho_grant", grant, 4'b0100);
        check_eq("ho_owner", owner, 2);
        check_eq("ho_busy",  busy,  1);
        check_eq("ho_rrptr", dut.rr_ptr, 1);
        req = '0;
        @(negedge clk);
        check_eq("ho_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
